// File: rtl/fas_serial.sv
// Digit-serial adder/subtractor: adds or subtracts two WIDTH-bit operands DIGIT bits per clock.
// Define FAS_SERIAL_OVF_EN to compute signed overflow; otherwise ovf is tied low.
module fas_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_ns,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCYC = WIDTH / DIGIT;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        count;
    logic                 carry;
    logic [WIDTH-1:0]     a_sr;
    logic [WIDTH-1:0]     b_sr;
    logic [DIGIT:0]       digit_sum;
    logic [WIDTH+DIGIT-1:0] s_cat;
    logic                 last;

    assign digit_sum = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry};
    // New digits enter s at the MSB end so the LSB digit lands at bit 0 after NCYC steps.
    assign s_cat     = {digit_sum[DIGIT-1:0], s};
    assign last      = (count == CW'(NCYC - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: B is inverted on accept and the initial carry supplies the +1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            carry <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            s     <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= a_ns ? b : ~b;
                        carry <= ~a_ns;
                        count <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    s     <= s_cat[WIDTH+DIGIT-1:DIGIT];
                    carry <= digit_sum[DIGIT];
                    count <= count + CW'(1);
                    if (last) begin
                        cout <= digit_sum[DIGIT];
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FAS_SERIAL_OVF_EN
    logic msb_cin;
    logic ovf_q;

    // The carry into the top bit is recovered from its sum bit: c = s ^ a ^ b.
    assign msb_cin = digit_sum[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_q <= msb_cin ^ digit_sum[DIGIT];
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fas_serial.sv
// Self-checking bench for fas_serial: an arithmetic reference model checked every cycle,
// plus literal expectations, and a DIGIT=4 instance for the multi-bit-digit case.
module tb_fas_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, a_ns, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, s;

    logic       in_valid4, in_ready4, a_ns4, out_valid4, out_ready4, cout4, ovf4;
    logic [7:0] a4, b4, s4;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    fas_serial #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .a_ns(a_ns), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf)
    );

    fas_serial #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .a_ns(a_ns4), .out_valid(out_valid4), .out_ready(out_ready4),
        .s(s4), .cout(cout4), .ovf(ovf4)
    );

`ifdef FAS_SERIAL_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: transaction-level view (phase 0 idle, 1 busy, 2 result held).
    int         m_phase = 0;
    int         m_left  = 0;
    logic       m_armed = 1'b0;
    logic [7:0] m_a, m_b, m_s = 8'h00;
    logic       m_op, m_cout = 1'b0, m_ovf = 1'b0;

    always @(posedge clk) begin
        logic [8:0] full;
        if (!rst_n) begin
            m_phase = 0; m_s = 8'h00; m_cout = 1'b0; m_ovf = 1'b0; m_armed = 1'b1;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_a = a; m_b = b; m_op = a_ns; m_left = 8; m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        full   = m_op ? ({1'b0, m_a} + {1'b0, m_b})
                                      : ({1'b0, m_a} + {1'b0, ~m_b} + 9'd1);
                        m_s    = full[7:0];
                        m_cout = full[8];
                        m_ovf  = OVF_ON & (m_op ? (m_a[7] == m_b[7]) && (m_s[7] != m_a[7])
                                                : (m_a[7] != m_b[7]) && (m_s[7] != m_a[7]));
                        m_phase = 2;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_armed) begin
            checkOutput("in_ready",  {31'd0, in_ready},  {31'd0, m_phase == 0});
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
            if (m_phase != 1) checkOutput("s", {24'd0, s}, {24'd0, m_s});
            checkOutput("cout", {31'd0, cout}, {31'd0, m_cout});
            checkOutput("ovf",  {31'd0, ovf},  {31'd0, m_ovf});
        end
    end

    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_v, input logic top);
        a = ta; b = tb_v; a_ns = top; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic runOp(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic top, input logic [7:0] es, input logic ec, input logic eo);
        int cyc;
        applyStimulus(ta, tb_v, top);
        waitResult(cyc);
        checkOutput({name, "_latency"}, cyc, 8);
        checkOutput({name, "_s"},    {24'd0, s},    {24'd0, es});
        checkOutput({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
        checkOutput({name, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
        releaseResult();
        checkOutput({name, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; a_ns = 1'b1; out_ready = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; a_ns4 = 1'b1; out_ready4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_s",         {24'd0, s},         32'd0);

        $display("[TB] add wrap and overflow cases");
        runOp("add_ff_01", 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0);
        runOp("add_7f_01", 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, OVF_ON);
        $display("[TB] subtract cases");
        runOp("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b1, 1'b0);
        runOp("sub_03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0);
        runOp("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, OVF_ON);
        runOp("add_5a_c3", 8'h5A, 8'hC3, 1'b1, 8'h1D, 1'b1, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(8'h12, 8'h34, 1'b1);
        waitResult(cyc);
        checkOutput("bp_latency", cyc, 8);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin a = 8'hEE; b = 8'hEE; in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(negedge clk);
            checkOutput("bp_hold_s", {24'd0, s}, 32'h46);
            checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        releaseResult();
        checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("bp_kept_s", {24'd0, s}, 32'h46);

        $display("[TB] reset mid-operation");
        applyStimulus(8'hAA, 8'h11, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("mid_rst_s",         {24'd0, s},         32'd0);
        runOp("add_10_20", 8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0);

        $display("[TB] DIGIT=4 instance");
        a4 = 8'h9C; b4 = 8'h75; a_ns4 = 1'b1; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        cyc = 0;
        while (!out_valid4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("d4_latency", cyc, 2);
        checkOutput("d4_s",    {24'd0, s4},    32'h11);
        checkOutput("d4_cout", {31'd0, cout4}, 32'd1);
        checkOutput("d4_ovf",  {31'd0, ovf4},  32'd0);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        checkOutput("d4_in_ready", {31'd0, in_ready4}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
